// File: rtl/spi_fsm_controller_if.sv
// -----------------------------------------------------------------------------
// spi_fsm_controller_if
//   Bundles the conditioned SPI inputs and the control strobes exchanged
//   between the SPI slave sequencing FSM and the rest of the memory slave.
//
//   Signals:
//     cs_n          conditioned chip select, active low (level)
//     sclk_posedge  one-clk strobe per conditioned SCLK rising edge
//     rw_bit        shift-register bit 0 (R/W bit once the address is in)
//     addr_we       one-clk pulse: latch address from shift register
//     sr_we         one-clk pulse: parallel-load shift register from memory
//     dm_we         one-clk pulse: write shift-register byte to memory
//     miso_buff     MISO tristate enable, high during read data
//     busy          high whenever the FSM is not idle
//
//   Modports:
//     master  drives the SPI-side inputs, observes the strobes
//     slave   the sequencing FSM itself
// -----------------------------------------------------------------------------
interface spi_fsm_controller_if;
   logic cs_n;
   logic sclk_posedge;
   logic rw_bit;
   logic addr_we;
   logic sr_we;
   logic dm_we;
   logic miso_buff;
   logic busy;

   modport master (
      output cs_n,
      output sclk_posedge,
      output rw_bit,
      input  addr_we,
      input  sr_we,
      input  dm_we,
      input  miso_buff,
      input  busy
   );

   modport slave (
      input  cs_n,
      input  sclk_posedge,
      input  rw_bit,
      output addr_we,
      output sr_we,
      output dm_we,
      output miso_buff,
      output busy
   );
endinterface

// File: rtl/spi_fsm_controller.sv
// -----------------------------------------------------------------------------
// spi_fsm_controller
//   Sequencing FSM for the SPI memory slave. A transaction is an address
//   phase (ADDR_BITS address bits followed by one R/W bit) and then a
//   DATA_BITS data phase. The FSM issues the address-latch, shift-register
//   load and memory write strobes and enables the MISO buffer while read
//   data is shifted out. All outputs are registered (Moore).
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; forces IDLE and clears outputs
//     bus    spi_fsm_controller_if.slave
//              in : cs_n, sclk_posedge, rw_bit
//              out: addr_we, sr_we, dm_we, miso_buff, busy
// -----------------------------------------------------------------------------

// Runtime protocol checks on the registered controller outputs.
module spi_fsm_controller_checker (
   input logic clk,
   input logic reset,
   input logic cs_n,
   input logic addr_we,
   input logic sr_we,
   input logic dm_we,
   input logic miso_buff,
   input logic busy
);
   // At most one memory-side strobe per cycle.
   strobe_onehot_a : assert property (@(posedge clk) disable iff (reset)
      $onehot0({addr_we, sr_we, dm_we}));

   // The MISO buffer is only ever enabled inside a transaction.
   miso_busy_a : assert property (@(posedge clk) disable iff (reset)
      miso_buff |-> busy);

   // Once cs_n is seen high no strobe may follow.
   abort_a : assert property (@(posedge clk) disable iff (reset)
      cs_n |=> !(addr_we || sr_we || dm_we));
endmodule

module spi_fsm_controller #(
   parameter int unsigned ADDR_BITS = 7,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   spi_fsm_controller_if.slave  bus
);

   // Address phase includes the trailing R/W bit.
   localparam int unsigned ADDR_TERM = ADDR_BITS + 1;
   localparam int unsigned MAX_TERM  = (ADDR_TERM > DATA_BITS) ? ADDR_TERM : DATA_BITS;
   localparam int unsigned CNT_W     = $clog2(MAX_TERM + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_TERM);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      GET_ADDR    = 4'd1,
      GOT_ADDR    = 4'd2,
      READ_WAIT   = 4'd3,
      READ_LOAD   = 4'd4,
      READ_SHIFT  = 4'd5,
      WRITE_SHIFT = 4'd6,
      WRITE_MEM   = 4'd7,
      DONE        = 4'd8
   } state_t;

   // Increment that sticks at the terminal value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] cnt,
      input logic [CNT_W-1:0] last
   );
      logic [CNT_W-1:0] res;
      if (cnt >= last) begin
         res = last;
      end else begin
         res = cnt + CNT_ONE;
      end
      return res;
   endfunction

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             addr_we_q,   addr_we_d;
   logic             sr_we_q,     sr_we_d;
   logic             dm_we_q,     dm_we_d;
   logic             miso_buff_q, miso_buff_d;
   logic             busy_q,      busy_d;

   logic [CNT_W-1:0] addr_inc_s;
   logic [CNT_W-1:0] data_inc_s;

   assign addr_inc_s = sat_inc(count_q, ADDR_LAST);
   assign data_inc_s = sat_inc(count_q, DATA_LAST);

   // Next-state and bit-counter logic; a high cs_n overrides everything.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if ((state_q != IDLE) && bus.cs_n) begin
         state_d = IDLE;
         count_d = CNT_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               count_d = CNT_ZERO;
               if (!bus.cs_n) begin
                  state_d = GET_ADDR;
               end else begin
                  state_d = IDLE;
               end
            end
            GET_ADDR: begin
               if (bus.sclk_posedge) begin
                  count_d = addr_inc_s;
                  if (addr_inc_s == ADDR_LAST) begin
                     state_d = GOT_ADDR;
                  end else begin
                     state_d = GET_ADDR;
                  end
               end else begin
                  state_d = GET_ADDR;
               end
            end
            GOT_ADDR: begin
               // rw_bit now holds the last bit shifted in: the R/W flag.
               count_d = CNT_ZERO;
               if (bus.rw_bit) begin
                  state_d = READ_WAIT;
               end else begin
                  state_d = WRITE_SHIFT;
               end
            end
            READ_WAIT: begin
               // One idle cycle for the memory read to settle.
               state_d = READ_LOAD;
            end
            READ_LOAD: begin
               state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
               if (bus.sclk_posedge) begin
                  count_d = data_inc_s;
                  if (data_inc_s == DATA_LAST) begin
                     state_d = DONE;
                  end else begin
                     state_d = READ_SHIFT;
                  end
               end else begin
                  state_d = READ_SHIFT;
               end
            end
            WRITE_SHIFT: begin
               if (bus.sclk_posedge) begin
                  count_d = data_inc_s;
                  if (data_inc_s == DATA_LAST) begin
                     state_d = WRITE_MEM;
                  end else begin
                     state_d = WRITE_SHIFT;
                  end
               end else begin
                  state_d = WRITE_SHIFT;
               end
            end
            WRITE_MEM: begin
               state_d = DONE;
            end
            DONE: begin
               // Only cs_n going high (handled above) leaves DONE.
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
               count_d = CNT_ZERO;
            end
         endcase
      end
   end

   // Outputs decoded from the next state so the flops line up with state_q.
   always_comb begin
      addr_we_d   = 1'b0;
      sr_we_d     = 1'b0;
      dm_we_d     = 1'b0;
      miso_buff_d = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_d)
         GOT_ADDR:   addr_we_d   = 1'b1;
         READ_LOAD:  sr_we_d     = 1'b1;
         READ_SHIFT: miso_buff_d = 1'b1;
         WRITE_MEM:  dm_we_d     = 1'b1;
         default: begin
            addr_we_d   = 1'b0;
            sr_we_d     = 1'b0;
            dm_we_d     = 1'b0;
            miso_buff_d = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= CNT_ZERO;
         addr_we_q   <= 1'b0;
         sr_we_q     <= 1'b0;
         dm_we_q     <= 1'b0;
         miso_buff_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_we_q   <= addr_we_d;
         sr_we_q     <= sr_we_d;
         dm_we_q     <= dm_we_d;
         miso_buff_q <= miso_buff_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.addr_we   = addr_we_q;
   assign bus.sr_we     = sr_we_q;
   assign bus.dm_we     = dm_we_q;
   assign bus.miso_buff = miso_buff_q;
   assign bus.busy      = busy_q;

   spi_fsm_controller_checker u_checker (
      .clk       (clk),
      .reset     (reset),
      .cs_n      (bus.cs_n),
      .addr_we   (addr_we_q),
      .sr_we     (sr_we_q),
      .dm_we     (dm_we_q),
      .miso_buff (miso_buff_q),
      .busy      (busy_q)
   );

endmodule

// File: tb/tb_spi_fsm_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm_controller
//   Directed self-checking bench for spi_fsm_controller (ADDR_BITS=7,
//   DATA_BITS=8). Inputs change 1 ns after each rising clock edge and the
//   registered outputs are sampled at the same point. Output vectors are
//   packed as {addr_we, sr_we, dm_we, miso_buff, busy}.
// -----------------------------------------------------------------------------
module tb_spi_fsm_controller;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_err    = 0;

   int cnt_addr;
   int cnt_sr;
   int cnt_dm;
   int cnt_miso;

   spi_fsm_controller_if bus ();

   spi_fsm_controller #(
      .ADDR_BITS (7),
      .DATA_BITS (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy};
      chk(tag, {27'd0, obs}, {27'd0, exp});
   endtask

   task automatic clr_cnt();
      cnt_addr = 0;
      cnt_sr   = 0;
      cnt_dm   = 0;
      cnt_miso = 0;
   endtask

   // Drive one cycle of inputs, step past the edge, tally strobes.
   task automatic tick(input logic cs, input logic sp, input logic rw);
      bus.cs_n         = cs;
      bus.sclk_posedge = sp;
      bus.rw_bit       = rw;
      @(posedge clk);
      #1;
      if (bus.addr_we === 1'b1)   cnt_addr++;
      if (bus.sr_we === 1'b1)     cnt_sr++;
      if (bus.dm_we === 1'b1)     cnt_dm++;
      if (bus.miso_buff === 1'b1) cnt_miso++;
   endtask

   // From IDLE: select, 7 address bits MSB first, then the R/W bit.
   // Leaves the FSM in GOT_ADDR with rw_bit still driven to rw.
   task automatic addr_phase(input logic [6:0] addr, input logic rw);
      logic b;
      tick(1'b0, 1'b0, 1'b0);
      chk_outs("addr_enter", 5'b00001);
      for (int i = 0; i < 8; i++) begin
         b = (i < 7) ? addr[6 - i] : rw;
         tick(1'b0, 1'b1, b);
         if (i == 6) chk_outs("addr_7th_no_we", 5'b00001);
         if (i < 7) tick(1'b0, 1'b0, b);
      end
      chk_outs("addr_we_pulse", 5'b10001);
   endtask

   initial begin
      reset            = 1'b1;
      bus.cs_n         = 1'b0;
      bus.sclk_posedge = 1'b0;
      bus.rw_bit       = 1'b0;
      clr_cnt();

      // 1: reset held with bus activity
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, ~i[0], i[0]);
         chk_outs("reset_hold", 5'b00000);
      end
      reset = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("idle_after_reset", 5'b00000);

      // 2: write to 0x2A
      clr_cnt();
      addr_phase(7'h2A, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk_outs("write_shift", 5'b00001);
      for (int j = 0; j < 8; j++) begin
         tick(1'b0, 1'b1, j[0]);
         if (j == 6) chk_outs("write_7th", 5'b00001);
         if (j == 7) chk_outs("write_dm_pulse", 5'b00101);
      end
      tick(1'b0, 1'b0, 1'b0);
      chk_outs("write_done", 5'b00001);
      chk("write_addr_cnt", cnt_addr, 1);
      chk("write_dm_cnt",   cnt_dm,   1);
      chk("write_sr_cnt",   cnt_sr,   0);
      chk("write_miso_cnt", cnt_miso, 0);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("write_deselect", 5'b00000);

      // 3: read from 0x15, with SCLK strobes that must be ignored
      clr_cnt();
      addr_phase(7'h15, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      chk_outs("read_wait", 5'b00001);
      tick(1'b0, 1'b1, 1'b1);
      chk_outs("read_load_sr_we", 5'b01001);
      tick(1'b0, 1'b1, 1'b1);
      chk_outs("read_shift_miso", 5'b00011);
      for (int j = 0; j < 8; j++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (j == 6) chk_outs("read_7th_miso", 5'b00011);
         if (j == 7) chk_outs("read_done", 5'b00001);
      end
      chk("read_miso_cnt", cnt_miso, 8);
      chk("read_sr_cnt",   cnt_sr,   1);
      chk("read_dm_cnt",   cnt_dm,   0);
      chk("read_addr_cnt", cnt_addr, 1);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("read_deselect", 5'b00000);

      // 4: abort a write after 5 data bits
      clr_cnt();
      addr_phase(7'h33, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 5; j++) tick(1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("abort_idle", 5'b00000);
      tick(1'b1, 1'b1, 1'b0);
      chk_outs("abort_stay_idle", 5'b00000);
      chk("abort_dm_cnt", cnt_dm, 0);
      addr_phase(7'h0F, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("abort_clean_deselect", 5'b00000);
      chk("abort_addr_cnt", cnt_addr, 2);

      // 5: cs_n rises together with the 8th address strobe
      clr_cnt();
      tick(1'b0, 1'b0, 1'b0);
      chk_outs("cs8_enter", 5'b00001);
      for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      chk_outs("cs8_idle", 5'b00000);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("cs8_still_idle", 5'b00000);
      chk("cs8_addr_cnt", cnt_addr, 0);

      // 6: cs_n held low through 40 strobes after DONE
      clr_cnt();
      addr_phase(7'h01, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 8; j++) tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("hold_dm_cnt", cnt_dm, 1);
      clr_cnt();
      for (int k = 0; k < 40; k++) tick(1'b0, 1'b1, k[0]);
      chk("hold_no_strobes", cnt_addr + cnt_sr + cnt_dm + cnt_miso, 0);
      chk_outs("hold_busy", 5'b00001);
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("hold_release", 5'b00000);

      // 7: asynchronous reset while addr_we is high
      addr_phase(7'h7F, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk_outs("async_reset_drop", 5'b00000);
      tick(1'b0, 1'b1, 1'b1);
      chk_outs("async_reset_hold", 5'b00000);
      reset = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      chk_outs("post_reset_idle", 5'b00000);
      tick(1'b0, 1'b0, 1'b0);
      chk_outs("post_reset_start", 5'b00001);
      tick(1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
